// File: rtl/uc_seq.sv
// Microcode sequencer for the single-cycle datapath: RUN/HALT/RESUME control FSM with combinational decode.
// Optional retired-instruction counter is built only when UC_RETIRE_CNT_EN is defined.
module uc_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             resume,
  input  logic             cnt_clr,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALT   = 2'd1,
    ST_RESUME = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic       s_inc_s;
  logic       s_inm_s;
  logic       we3_s;
  logic       wez_s;
  logic [2:0] op_s;

  // State register; reset returns to RUN from any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and zero-latency decode; reset forces the safe "PC+1, no writes" pattern.
  always_comb begin
    state_nxt_s = state_r;
    s_inc_s     = 1'b1;
    s_inm_s     = 1'b0;
    we3_s       = 1'b0;
    wez_s       = 1'b0;
    op_s        = 3'b000;
    if (!reset) begin
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (Opcode[5]) begin
            op_s  = Opcode[4:2];
            we3_s = 1'b1;
            wez_s = 1'b1;
          end else if (Opcode[4:2] == 3'b000) begin
            s_inm_s = 1'b1;
            we3_s   = 1'b1;
          end else begin
            case (Opcode[4:0])
              5'b00100: s_inc_s = 1'b0;
              5'b00101: s_inc_s = ~z;
              5'b00110: s_inc_s = z;
              5'b00111: begin
                // HALT word holds its own address, so the PC parks on it.
                s_inc_s     = 1'b0;
                state_nxt_s = ST_HALT;
              end
              default:  s_inc_s = 1'b1;
            endcase
          end
        end
        ST_HALT: begin
          s_inc_s = 1'b0;
          if (resume) begin
            state_nxt_s = ST_RESUME;
          end else begin
            state_nxt_s = ST_HALT;
          end
        end
        ST_RESUME: begin
          state_nxt_s = ST_RUN;
        end
        default: begin
          state_nxt_s = ST_RUN;
        end
      endcase
    end
  end

  assign s_inc  = s_inc_s;
  assign s_inm  = s_inm_s;
  assign we3    = we3_s;
  assign wez    = wez_s;
  assign Op     = op_s;
  assign halted = (state_r == ST_HALT);

`ifdef UC_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Saturating retire counter; clear has priority over the RUN increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (cnt_clr) begin
      cnt_r <= '0;
    end else if ((state_r == ST_RUN) && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign instr_cnt = cnt_r;
`else
  logic unused_cnt_clr_s;

  assign unused_cnt_clr_s = cnt_clr;
  assign instr_cnt        = '0;
`endif

endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: directed vectors plus a per-cycle behavioural model comparison.
module tb_uc_seq;
  localparam int CNT_W = 4;
`ifdef UC_RETIRE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  localparam int CNT_MAX = CNT_ON ? ((1 << CNT_W) - 1) : 0;

  logic             clk     = 1'b0;
  logic             reset   = 1'b0;
  logic [5:0]       Opcode  = 6'b100100;
  logic             z       = 1'b0;
  logic             resume  = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             s_inc, s_inm, we3, wez, halted;
  logic [2:0]       Op;
  logic [CNT_W-1:0] instr_cnt;

  int checks   = 0;
  int failures = 0;

  // model: sequencer is halted, in its one-cycle resume slot, or running
  bit m_halt = 1'b0;
  bit m_resm = 1'b0;
  int m_cnt  = 0;

  uc_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .resume(resume), .cnt_clr(cnt_clr),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op), .halted(halted),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {s_inc,s_inm,we3,wez,Op[2:0]} from the instruction-set rules.
  function automatic logic [6:0] exp_outs(input bit rst_low, input bit hlt, input bit resm,
                                          input logic [5:0] op, input logic zz);
    if (rst_low || resm) return 7'b1000000;
    if (hlt)             return 7'b0000000;
    if (op[5])           return {4'b1011, op[4:2]};
    if (op < 6'd4)       return 7'b1110000;
    if (op == 6'd4)      return 7'b0000000;
    if (op == 6'd5)      return {~zz, 6'b000000};
    if (op == 6'd6)      return {zz, 6'b000000};
    if (op == 6'd7)      return 7'b0000000;
    return 7'b1000000;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_halt <= 1'b0;
      m_resm <= 1'b0;
      m_cnt  <= 0;
    end else begin
      if (cnt_clr) m_cnt <= 0;
      else if (!m_halt && !m_resm && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      if (m_halt) begin
        if (resume) begin
          m_halt <= 1'b0;
          m_resm <= 1'b1;
        end
      end else if (m_resm) m_resm <= 1'b0;
      else if (Opcode == 6'b000111) m_halt <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("model_outs", {s_inc, s_inm, we3, wez, Op}, exp_outs(!reset, m_halt, m_resm, Opcode, z));
    chk("model_halted", halted, m_halt);
    chk("model_cnt", instr_cnt, m_cnt);
  end

  task automatic drive(input logic [5:0] op, input logic zz, input logic res, input logic clr);
    @(posedge clk);
    #2;
    Opcode = op; z = zz; resume = res; cnt_clr = clr;
    #1;
  endtask

  initial begin
    @(posedge clk);
    #3;
    chk("rst_outs", {s_inc, s_inm, we3, wez, Op}, 7'b1000000);
    chk("rst_halted", halted, 1'b0);
    chk("rst_cnt", instr_cnt, 0);
    reset = 1'b1;

    drive(6'b100100, 1'b0, 1'b0, 1'b0);
    chk("alu_op1", {s_inc, s_inm, we3, wez, Op}, 7'b1011001);
    drive(6'b000101, 1'b1, 1'b0, 1'b0);
    chk("jz_z1", s_inc, 1'b0);
    drive(6'b000101, 1'b0, 1'b0, 1'b0);
    chk("jz_z0", s_inc, 1'b1);
    drive(6'b000110, 1'b0, 1'b0, 1'b0);
    chk("jnz_z0", s_inc, 1'b0);
    drive(6'b000110, 1'b1, 1'b0, 1'b0);
    chk("jnz_z1", s_inc, 1'b1);
    drive(6'b000100, 1'b0, 1'b0, 1'b0);
    chk("jump", {s_inc, s_inm, we3, wez, Op}, 7'b0000000);
    drive(6'b000010, 1'b0, 1'b0, 1'b0);
    chk("li", {s_inc, s_inm, we3, wez, Op}, 7'b1110000);

    // HALT decoded together with a resume pulse: the pulse must be ignored
    drive(6'b000111, 1'b0, 1'b1, 1'b0);
    chk("halt_decode", {s_inc, we3, halted}, 3'b000);
    drive(6'b100100, 1'b0, 1'b0, 1'b0);
    chk("halt_entered", {halted, s_inc, we3, wez}, 4'b1000);
    chk("halt_cnt", instr_cnt, CNT_ON ? 9 : 0);
    for (int i = 0; i < 5; i++) begin
      drive(6'b100100, 1'b0, 1'b0, 1'b0);
      chk("halt_hold", {halted, we3}, 2'b10);
      chk("halt_hold_cnt", instr_cnt, CNT_ON ? 9 : 0);
    end
    drive(6'b100100, 1'b0, 1'b1, 1'b0);
    chk("resume_pulse", {halted, s_inc}, 2'b10);
    drive(6'b100100, 1'b0, 1'b1, 1'b0);
    chk("resume_cycle", {halted, s_inc, s_inm, we3, wez, Op}, 8'b01000000);
    drive(6'b100100, 1'b0, 1'b0, 1'b0);
    chk("back_to_run", {halted, we3, wez}, 3'b011);
    chk("resume_cnt", instr_cnt, CNT_ON ? 9 : 0);

    for (int i = 0; i < 20; i++) drive(6'b001000, 1'b0, 1'b0, 1'b0);
    chk("cnt_saturate", instr_cnt, CNT_ON ? 15 : 0);
    drive(6'b001000, 1'b0, 1'b0, 1'b1);
    chk("cnt_no_wrap", instr_cnt, CNT_ON ? 15 : 0);
    drive(6'b001000, 1'b0, 1'b0, 1'b0);
    chk("cnt_cleared", instr_cnt, 0);
    drive(6'b001000, 1'b0, 1'b0, 1'b0);
    chk("cnt_after_clr", instr_cnt, CNT_ON ? 1 : 0);

    // asynchronous reset in the middle of HALT
    drive(6'b000111, 1'b0, 1'b0, 1'b0);
    drive(6'b000111, 1'b0, 1'b0, 1'b0);
    chk("halt_again", halted, 1'b1);
    reset = 1'b0;
    #1;
    chk("async_rst_halted", halted, 1'b0);
    chk("async_rst_cnt", instr_cnt, 0);
    chk("async_rst_outs", {s_inc, s_inm, we3, wez, Op}, 7'b1000000);
    @(posedge clk);
    #2;
    reset = 1'b1;
    drive(6'b100100, 1'b0, 1'b0, 1'b0);
    chk("post_rst_decode", halted, 1'b1);
    chk("post_rst_cnt", instr_cnt, CNT_ON ? 1 : 0);
    drive(6'b100100, 1'b0, 1'b1, 1'b0);
    drive(6'b100100, 1'b0, 1'b0, 1'b0);
    drive(6'b100100, 1'b0, 1'b0, 1'b0);
    chk("final_run", {halted, we3, Op}, 5'b01001);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uc_seq.md
UC_SEQ -- requirements
Module: uc_seq

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock, shared with the datapath.
REQ-004 reset  in  1  asynchronous active-low reset; 0 = reset asserted.
REQ-005 Opcode  in  6  instr[15:10] from the datapath.
REQ-006 z  in  1  registered zero flag from the datapath.
REQ-007 resume  in  1  single-cycle pulse that releases HALT; sampled only in HALT.
REQ-008 cnt_clr  in  1  synchronous clear of instr_cnt.
REQ-009 s_inc  out  1  1 = PC+1; 0 = load instr[9:0].
REQ-010 s_inm  out  1  1 = immediate path (LI).
REQ-011 we3  out  1  register-file write enable.
REQ-012 wez  out  1  zero-flag write enable.
REQ-013 Op  out  3  ALU operation.
REQ-014 halted  out  1  1 while the FSM is in HALT.
REQ-015 instr_cnt  out  CNT_W  retired-instruction count.

Function
REQ-016 FSM states SHALL be RUN, HALT and RESUME, encoded in registered state.
REQ-017 Outputs s_inc, s_inm, we3, wez and Op SHALL be combinational from state, Opcode and z (zero latency, single-cycle datapath).
REQ-018 In RUN, decoding SHALL be:
  - Opcode[5]=1: ALU; Op=Opcode[4:2]; we3=1; wez=1; s_inm=0; s_inc=1.
  - 0000xx: LI; s_inm=1; Op=000; we3=1; wez=0; s_inc=1.
  - 000100: J; s_inc=0.
  - 000101: JZ; s_inc=~z.
  - 000110: JNZ; s_inc=z.
  - 000111: HALT; s_inc=0; next state HALT.
  - All others: NOP; s_inc=1.
REQ-019 Non-ALU, non-LI opcodes SHALL drive we3=0, wez=0, s_inm=0 and Op=000.
REQ-020 HALT instructions SHALL carry their own address in instr[9:0]; with s_inc=0 the PC holds on the HALT word.
REQ-021 In HALT: s_inc=0, we3=0, wez=0, s_inm=0, Op=000, halted=1; resume=1 → RESUME, otherwise stay.
REQ-022 In RESUME, for exactly one cycle: s_inc=1, we3=0, wez=0; next state RUN.
REQ-023 Jump conditions SHALL use the z value present in the same cycle; a flag written by the current instruction affects only later instructions.
REQ-024 resume in RUN or RESUME SHALL be ignored; resume in the cycle HALT is decoded SHALL be ignored.
REQ-025 instr_cnt SHALL increment by 1 on each clock edge in RUN, including the HALT instruction itself, and SHALL saturate at all-ones.
REQ-026 cnt_clr=1 SHALL load 0 on the next edge; clear wins over a simultaneous increment.

Reset
REQ-027 reset=0 SHALL force, asynchronously: state=RUN, instr_cnt=0, halted=0.
REQ-028 While reset=0, outputs SHALL be s_inc=1, s_inm=0, we3=0, wez=0, Op=000.
REQ-029 Reset asserted in HALT or RESUME SHALL return the FSM to RUN; the first edge after release decodes normally.

Configuration
REQ-030 Macro UC_RETIRE_CNT_EN defined: instr_cnt and cnt_clr are functional per REQ-025/026.
REQ-031 Macro UC_RETIRE_CNT_EN undefined: no counter flops; instr_cnt is tied to 0; cnt_clr is ignored; ports remain present.

Verification
REQ-032 Release reset, Opcode=100100 (ALU, Op=001) → s_inc=1, we3=1, wez=1, Op=001, s_inm=0.
REQ-033 Opcode=000101 with z=1 → s_inc=0. Opcode=000101 with z=0 → s_inc=1. Opcode=000110 with z=0 → s_inc=0.
REQ-034 Opcode=000111 → halted=1 from the next edge, s_inc=0, we3=0. Hold 5 cycles → halted stays 1 and instr_cnt is unchanged. Pulse resume → one cycle s_inc=1 with we3=0, then RUN.
REQ-035 resume pulsed in the same cycle as HALT decode → HALT is entered and held; a later resume is required to leave.
REQ-036 Set CNT_W=4; run 20 NOPs → instr_cnt=F. Assert cnt_clr with a NOP → instr_cnt=0.
REQ-037 Assert reset low mid-HALT → halted=0 and instr_cnt=0 immediately, without waiting for a clock edge.
